// File: rtl/lfsr_check.sv
// Receive-side PRN checker: two independent channels (32b data, 10b addr) that self-sync,
// track the incoming sequence, and flag and count mismatches. Optional first-error capture: LFSR_CHECK_CAPTURE_EN.

module lfsr_check_chan #(
  parameter int unsigned W          = 32,
  parameter logic [W-1:0] TAPS      = '0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [W-1:0]     sample,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W-1:0]     exp_word,
  output logic             err_c
);

  localparam int unsigned MATCH_W = 4;
  localparam int unsigned MISS_W  = 8;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(ERR_THRESH - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t             state;
  logic [MATCH_W-1:0] match;
  logic [MISS_W-1:0]  miss;
  logic               hit;

  // Fibonacci step: shift left, parity of tapped bits into bit 0.
  function automatic logic [W-1:0] nxt(input logic [W-1:0] v);
    return {v[W-2:0], ^(v & TAPS)};
  endfunction

  assign hit   = (sample == exp_word);
  assign err_c = en && (state == LOCKED) && !hit;

  // Sync/track FSM; a disabled cycle leaves everything but the err pulse untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= SEARCH;
      exp_word <= '0;
      match    <= '0;
      miss     <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= err_c;
      if (en) begin
        case (state)
          SEARCH: begin
            if (|sample) begin
              exp_word <= nxt(sample);
              match    <= '0;
              state    <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit) begin
              exp_word <= nxt(exp_word);
              if (match == MATCH_LAST) begin
                match  <= '0;
                miss   <= '0;
                locked <= 1'b1;
                state  <= LOCKED;
              end else begin
                match <= match + 1'b1;
              end
            end else if (|sample) begin
              exp_word <= nxt(sample);
              match    <= '0;
            end else begin
              match <= '0;
              state <= SEARCH;
            end
          end
          LOCKED: begin
            // Once locked, the local sequence free-runs; bad words never reseed it.
            exp_word <= nxt(exp_word);
            if (hit) begin
              miss <= '0;
            end else if (miss == MISS_LAST) begin
              miss   <= '0;
              locked <= 1'b0;
              state  <= SEARCH;
            end else begin
              miss <= miss + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Saturating error counter; an error coinciding with clear leaves a count of one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= err_c ? CNT_W'(1) : '0;
    end else if (err_c && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

module lfsr_check #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_data,
  input  logic [31:0]      lfsr_data,
  input  logic             en_addr,
  input  logic [9:0]       lfsr_addr,
  input  logic             clr_err,
  output logic             data_locked,
  output logic             addr_locked,
  output logic             data_err,
  output logic             addr_err,
  output logic [CNT_W-1:0] data_err_cnt,
  output logic [CNT_W-1:0] addr_err_cnt,
  output logic             cap_valid,
  output logic [31:0]      cap_exp,
  output logic [31:0]      cap_rcv
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam logic [DATA_W-1:0] DATA_TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1
  localparam logic [ADDR_W-1:0] ADDR_TAPS = 10'h240;        // x^10+x^7+1

  logic [DATA_W-1:0] data_exp;
  logic [ADDR_W-1:0] addr_exp;
  logic              data_err_c;
  logic              addr_err_c;

  lfsr_check_chan #(
    .W(DATA_W), .TAPS(DATA_TAPS), .LOCK_CNT(LOCK_CNT),
    .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
  ) u_data (
    .clk(clk), .rstn(rstn), .en(en_data), .sample(lfsr_data), .clr(clr_err),
    .locked(data_locked), .err(data_err), .err_cnt(data_err_cnt),
    .exp_word(data_exp), .err_c(data_err_c)
  );

  lfsr_check_chan #(
    .W(ADDR_W), .TAPS(ADDR_TAPS), .LOCK_CNT(LOCK_CNT),
    .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
  ) u_addr (
    .clk(clk), .rstn(rstn), .en(en_addr), .sample(lfsr_addr), .clr(clr_err),
    .locked(addr_locked), .err(addr_err), .err_cnt(addr_err_cnt),
    .exp_word(addr_exp), .err_c(addr_err_c)
  );

`ifdef LFSR_CHECK_CAPTURE_EN
  // First data error since reset/clear is held; a clear rearms and may take the same-cycle error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_valid <= 1'b0;
      cap_exp   <= '0;
      cap_rcv   <= '0;
    end else if (clr_err) begin
      cap_valid <= data_err_c;
      cap_exp   <= data_err_c ? data_exp  : '0;
      cap_rcv   <= data_err_c ? lfsr_data : '0;
    end else if (data_err_c && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_exp   <= data_exp;
      cap_rcv   <= lfsr_data;
    end
  end

  logic unused_addr;
  assign unused_addr = ^{addr_exp, addr_err_c};
`else
  assign cap_valid = 1'b0;
  assign cap_exp   = '0;
  assign cap_rcv   = '0;

  logic unused_cap;
  assign unused_cap = ^{data_exp, data_err_c, addr_exp, addr_err_c};
`endif

endmodule

// File: tb/tb_lfsr_check.sv
// Scoreboard bench for lfsr_check: stimulus pushes hand-derived expectations, a monitor
// pops and compares one entry per enabled sample. A narrow-counter instance covers saturation.

module tb_lfsr_check;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en_data = 1'b0;
  logic [31:0] lfsr_data = '0;
  logic        en_addr = 1'b0;
  logic [9:0]  lfsr_addr = '0;
  logic        clr_err = 1'b0;

  logic        data_locked, addr_locked, data_err, addr_err;
  logic [15:0] data_err_cnt, addr_err_cnt;
  logic        cap_valid;
  logic [31:0] cap_exp, cap_rcv;

  logic        s_data_locked, s_addr_locked, s_data_err, s_addr_err;
  logic [3:0]  s_data_err_cnt, s_addr_err_cnt;
  logic        s_cap_valid;
  logic [31:0] s_cap_exp, s_cap_rcv;

  lfsr_check u_dut (
    .clk(clk), .rstn(rstn), .en_data(en_data), .lfsr_data(lfsr_data),
    .en_addr(en_addr), .lfsr_addr(lfsr_addr), .clr_err(clr_err),
    .data_locked(data_locked), .addr_locked(addr_locked),
    .data_err(data_err), .addr_err(addr_err),
    .data_err_cnt(data_err_cnt), .addr_err_cnt(addr_err_cnt),
    .cap_valid(cap_valid), .cap_exp(cap_exp), .cap_rcv(cap_rcv)
  );

  lfsr_check #(.CNT_W(4)) u_sat (
    .clk(clk), .rstn(rstn), .en_data(en_data), .lfsr_data(lfsr_data),
    .en_addr(en_addr), .lfsr_addr(lfsr_addr), .clr_err(clr_err),
    .data_locked(s_data_locked), .addr_locked(s_addr_locked),
    .data_err(s_data_err), .addr_err(s_addr_err),
    .data_err_cnt(s_data_err_cnt), .addr_err_cnt(s_addr_err_cnt),
    .cap_valid(s_cap_valid), .cap_exp(s_cap_exp), .cap_rcv(s_cap_rcv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [3:0]  sat;
    logic        capv;
    logic [31:0] cape;
    logic [31:0] capr;
  } dexp_t;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
  } aexp_t;

  dexp_t dq[$];
  aexp_t aq[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic        ecv = 1'b0;
  logic [31:0] ece = '0;
  logic [31:0] ecr = '0;

  // Generator side of the PRN streams.
  function automatic logic [31:0] nd(input logic [31:0] d);
    return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
  endfunction

  function automatic logic [9:0] na(input logic [9:0] a);
    return {a[8:0], a[9] ^ a[6]};
  endfunction

  task automatic cyc(input logic ed, input logic [31:0] d, input logic ea,
                     input logic [9:0] a, input logic clr);
    @(posedge clk);
    #1;
    en_data   = ed;
    lfsr_data = d;
    en_addr   = ea;
    lfsr_addr = a;
    clr_err   = clr;
  endtask

  task automatic idle();
    cyc(1'b0, $urandom, 1'b0, 10'($urandom), 1'b0);
  endtask

  task automatic push_d(input logic locked, input logic err, input logic [15:0] cnt);
    dexp_t e;
    e.locked = locked;
    e.err    = err;
    e.cnt    = cnt;
    e.sat    = (cnt > 16'd15) ? 4'hF : cnt[3:0];
`ifdef LFSR_CHECK_CAPTURE_EN
    e.capv = ecv;
    e.cape = ece;
    e.capr = ecr;
`else
    e.capv = 1'b0;
    e.cape = '0;
    e.capr = '0;
`endif
    dq.push_back(e);
  endtask

  task automatic dsamp(input logic [31:0] w, input logic locked, input logic err,
                       input logic [15:0] cnt);
    push_d(locked, err, cnt);
    cyc(1'b1, w, 1'b0, 10'($urandom), 1'b0);
  endtask

  task automatic asamp(input logic [9:0] w, input logic locked, input logic err,
                       input logic [15:0] cnt);
    aexp_t e;
    e.locked = locked;
    e.err    = err;
    e.cnt    = cnt;
    aq.push_back(e);
    cyc(1'b0, $urandom, 1'b1, w, 1'b0);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s got %h want %h", name, act, req);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({data_locked, addr_locked, data_err, addr_err, data_err_cnt, addr_err_cnt,
                 s_data_err_cnt, cap_valid, cap_exp, cap_rcv});
  endfunction

  // Monitor: one scoreboard entry per enabled sample, checked after the sampling edge.
  initial begin
    logic  dv, av, rv;
    dexp_t de, da;
    aexp_t ae, aa;
    forever begin
      @(posedge clk);
      dv = en_data;
      av = en_addr;
      rv = rstn;
      @(negedge clk);
      if (rv && dv) begin
        n_checks++;
        if (dq.size() == 0) begin
          $display("FAIL data_unexpected_sample at %0t", $time);
        end else begin
          de = dq.pop_front();
          da = {data_locked, data_err, data_err_cnt, s_data_err_cnt, cap_valid, cap_exp, cap_rcv};
          if (da === de) n_pass++;
          else $display("FAIL data_sample at %0t got %h want %h", $time, da, de);
        end
      end
      if (rv && av) begin
        n_checks++;
        if (aq.size() == 0) begin
          $display("FAIL addr_unexpected_sample at %0t", $time);
        end else begin
          ae = aq.pop_front();
          aa = {addr_locked, addr_err, addr_err_cnt};
          if (aa === ae) n_pass++;
          else $display("FAIL addr_sample at %0t got %h want %h", $time, aa, ae);
        end
      end
    end
  end

  initial begin
    logic [31:0] dw;
    logic [9:0]  aw;
    logic [15:0] n;

    // Reset with random traffic: everything must stay zero.
    for (int i = 0; i < 5; i++) begin
      cyc(1'($urandom), $urandom, 1'($urandom), 10'($urandom), 1'($urandom));
      @(negedge clk);
      chk("reset_outputs", all_outs(), '0);
    end
    idle();
    @(negedge clk);
    rstn = 1'b1;

    // Data lock from seed 1: 1, 3, 6, ... locks after the fourth match.
    dw = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      dsamp(dw, (i == 4), 1'b0, 16'd0);
      dw = nd(dw);
    end
    for (int i = 0; i < 3; i++) begin
      dsamp(dw, 1'b1, 1'b0, 16'd0);
      dw = nd(dw);
    end

    // Addr lock with idle gaps between words.
    aw = 10'h001;
    for (int i = 0; i < 8; i++) begin
      asamp(aw, (i >= 4), 1'b0, 16'd0);
      aw = na(aw);
      idle();
    end
    asamp(aw ^ 10'h003, 1'b1, 1'b1, 16'd1);
    aw = na(aw);
    asamp(aw, 1'b1, 1'b0, 16'd1);
    aw = na(aw);

    // Single data error while locked.
    ecv = 1'b1; ece = dw; ecr = dw ^ 32'h1;
    dsamp(dw ^ 32'h1, 1'b1, 1'b1, 16'd1);
    dw = nd(dw);
    dsamp(dw, 1'b1, 1'b0, 16'd1);
    dw = nd(dw);
    dsamp(dw, 1'b1, 1'b0, 16'd1);
    dw = nd(dw);

    // Clear, then eight wrong words drop lock; the good stream relocks in 5 samples.
    cyc(1'b0, $urandom, 1'b0, 10'($urandom), 1'b1);
    ecv = 1'b1; ece = dw; ecr = dw ^ 32'h10;
    for (int i = 0; i < 8; i++) begin
      dsamp(dw ^ 32'h10, (i != 7), 1'b1, 16'(i + 1));
      dw = nd(dw);
    end
    for (int i = 0; i < 5; i++) begin
      dsamp(dw, (i == 4), 1'b0, 16'd8);
      dw = nd(dw);
    end

    // Clear coinciding with an error: count ends at one and capture takes it.
    ecv = 1'b1; ece = dw; ecr = dw ^ 32'h4;
    push_d(1'b1, 1'b1, 16'd1);
    cyc(1'b1, dw ^ 32'h4, 1'b0, 10'($urandom), 1'b1);
    dw = nd(dw);
    dsamp(dw, 1'b1, 1'b0, 16'd1);
    dw = nd(dw);

    // Asynchronous reset while locked.
    idle();
    @(negedge clk);
    chk("locked_before_reset", 128'({data_locked, addr_locked}), 128'(2'b11));
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), '0);
    ecv = 1'b0; ece = '0; ecr = '0;
    @(negedge clk);
    rstn = 1'b1;

    // Zero words in SEARCH are ignored, then a normal lock.
    for (int i = 0; i < 5; i++) dsamp(32'h0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      dsamp(dw, (i == 4), 1'b0, 16'd0);
      dw = nd(dw);
    end

    // 21 errors without losing lock; the 4-bit instance saturates at 15.
    n = 16'd0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 7; k++) begin
        n = n + 16'd1;
        if (n == 16'd1) begin
          ecv = 1'b1; ece = dw; ecr = dw ^ 32'h100;
        end
        dsamp(dw ^ 32'h100, 1'b1, 1'b1, n);
        dw = nd(dw);
      end
      dsamp(dw, 1'b1, 1'b0, n);
      dw = nd(dw);
    end

    repeat (4) idle();
    @(negedge clk);
    chk("scoreboard_drained", 128'(dq.size() + aq.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
